// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates LSB load/store and instruction fetch onto a byte-wide RAM/IO bus.
// Optional MEMCTRL_IO_STALL_EN holds write bytes to IO space (addr[17:16] = 2'b11) while io_buffer_full is high.
//
// state | meaning
// IDLE  | waiting for a request; write > read > fetch
// BUSY  | streaming bytes for the latched request
// DONE  | success pulse; requester inputs ignored while it de-asserts
module mem_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              jump_wrong,
    input  logic              lsb_read_signal,
    input  logic              lsb_write_signal,
    input  logic [1:0]        requiring_length,
    input  logic              lsb_load_signed,
    input  logic [ADDR_W-1:0] to_mem_addr,
    input  logic [31:0]       to_mem_data,
    output logic              mem_load_success,
    output logic              mem_store_success,
    output logic [31:0]       from_mem_data,
    input  logic              if_read_signal,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_success,
    output logic [31:0]       if_data,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
    typedef enum logic [1:0] {SEL_NONE = 2'd0, SEL_WR = 2'd1, SEL_RD = 2'd2, SEL_IF = 2'd3} sel_t;

    state_t            state, state_nxt;
    sel_t              sel, accept_sel;
    logic [2:0]        cnt, n_bytes;
    logic [ADDR_W-1:0] base, addr_cur;
    logic [1:0]        len, rd_idx;
    logic              sgn;
    logic [31:0]       wdata, rbuf, rd_word, rd_ext;
    logic              stall;

    assign n_bytes  = (len == 2'b00) ? 3'd1 : (len == 2'b01) ? 3'd2 : 3'd4;
    assign addr_cur = base + ADDR_W'(cnt);
    // Read data for byte i arrives two edges after its address, i.e. while cnt = i+1.
    assign rd_idx   = cnt[1:0] - 2'd1;

`ifdef MEMCTRL_IO_STALL_EN
    assign stall = (state == BUSY) && (sel == SEL_WR) && (addr_cur[17:16] == 2'b11) && io_buffer_full;
`else
    logic unused_io_buffer_full;
    assign unused_io_buffer_full = io_buffer_full;
    assign stall = 1'b0;
`endif

    always_comb begin
        rd_word = rbuf;
        rd_word[{rd_idx, 3'b000} +: 8] = mem_din;
    end

    always_comb begin
        rd_ext = rd_word;
        case (len)
            2'b00:   rd_ext = {{24{sgn & rd_word[7]}}, rd_word[7:0]};
            2'b01:   rd_ext = {{16{sgn & rd_word[15]}}, rd_word[15:0]};
            default: rd_ext = rd_word;
        endcase
    end

    always_comb begin
        state_nxt         = state;
        accept_sel        = SEL_NONE;
        mem_wr            = 1'b0;
        mem_a             = '0;
        mem_dout          = 8'h00;
        mem_load_success  = 1'b0;
        mem_store_success = 1'b0;
        if_success        = 1'b0;
        case (state)
            IDLE: begin
                if (lsb_write_signal)                    accept_sel = SEL_WR;
                else if (lsb_read_signal && !jump_wrong) accept_sel = SEL_RD;
                else if (if_read_signal && !jump_wrong)  accept_sel = SEL_IF;
                if (accept_sel != SEL_NONE) state_nxt = BUSY;
            end
            BUSY: begin
                mem_a = addr_cur;
                if (sel == SEL_WR) begin
                    mem_dout = wdata[{cnt[1:0], 3'b000} +: 8];
                    if (!stall) begin
                        mem_wr = 1'b1;
                        if (cnt == n_bytes - 3'd1) state_nxt = DONE;
                    end
                end else if (jump_wrong) begin
                    state_nxt = IDLE;
                end else if (cnt == n_bytes) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt         = IDLE;
                mem_store_success = (sel == SEL_WR);
                mem_load_success  = (sel == SEL_RD);
                if_success        = (sel == SEL_IF);
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            sel           <= SEL_NONE;
            cnt           <= 3'd0;
            base          <= '0;
            len           <= 2'b00;
            sgn           <= 1'b0;
            wdata         <= 32'h0;
            rbuf          <= 32'h0;
            from_mem_data <= 32'h0;
            if_data       <= 32'h0;
        end else if (rdy) begin
            state <= state_nxt;
            if (state_nxt != BUSY)                 cnt <= 3'd0;
            else if (state == BUSY && !stall)      cnt <= cnt + 3'd1;
            if (state == IDLE && accept_sel != SEL_NONE) begin
                sel   <= accept_sel;
                base  <= (accept_sel == SEL_IF) ? if_addr : to_mem_addr;
                len   <= (accept_sel == SEL_IF) ? 2'b10 : requiring_length;
                sgn   <= lsb_load_signed;
                wdata <= to_mem_data;
            end
            if (state == BUSY && sel != SEL_WR && cnt != 3'd0)
                rbuf[{rd_idx, 3'b000} +: 8] <= mem_din;
            if (state == BUSY && state_nxt == DONE) begin
                if (sel == SEL_IF)      if_data       <= rd_ext;
                else if (sel == SEL_RD) from_mem_data <= rd_ext;
            end
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed testbench for mem_ctrl with a small byte RAM model behind the bus.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst, rdy, jump_wrong;
    logic        lsb_read_signal, lsb_write_signal, lsb_load_signed;
    logic [1:0]  requiring_length;
    logic [31:0] to_mem_addr, to_mem_data, if_addr;
    logic        if_read_signal, io_buffer_full;
    logic [7:0]  mem_din;
    logic        mem_load_success, mem_store_success, if_success, mem_wr;
    logic [31:0] from_mem_data, if_data, mem_a;
    logic [7:0]  mem_dout;

    int errors = 0;
    int checks = 0;

    logic [7:0]  ram [0:4095];
    logic        pre_we = 1'b0;
    logic [11:0] pre_addr = 12'h0;
    logic [7:0]  pre_data = 8'h0;

    mem_ctrl #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .jump_wrong(jump_wrong),
        .lsb_read_signal(lsb_read_signal), .lsb_write_signal(lsb_write_signal),
        .requiring_length(requiring_length), .lsb_load_signed(lsb_load_signed),
        .to_mem_addr(to_mem_addr), .to_mem_data(to_mem_data),
        .mem_load_success(mem_load_success), .mem_store_success(mem_store_success),
        .from_mem_data(from_mem_data), .if_read_signal(if_read_signal), .if_addr(if_addr),
        .if_success(if_success), .if_data(if_data), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        mem_din <= ram[mem_a[11:0]];
        if (pre_we)      ram[pre_addr]    <= pre_data;
        else if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [11:0] a, input logic [7:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        tick();
        pre_we   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL reset_mem_wr: got %b want 0", mem_wr); end
        checks++; if (mem_a !== 32'h0) begin errors++; $display("FAIL reset_mem_a: got %h want 0", mem_a); end
        checks++; if ({mem_load_success, mem_store_success, if_success} !== 3'b000) begin
            errors++; $display("FAIL reset_pulses: got %b want 000", {mem_load_success, mem_store_success, if_success}); end
        checks++; if ({from_mem_data, if_data} !== 64'h0) begin
            errors++; $display("FAIL reset_data: got %h %h want 0 0", from_mem_data, if_data); end
        rst = 1'b0;
        tick();
    endtask

    // Issue a load and return the cycle (1 = edge E0) at which the pulse appears.
    task automatic do_load(input logic [31:0] a, input logic [1:0] len, input logic sg, output int got);
        to_mem_addr = a; requiring_length = len; lsb_load_signed = sg; lsb_read_signal = 1'b1;
        got = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (mem_load_success) begin got = k; break; end
        end
        lsb_read_signal = 1'b0;
        tick();
    endtask

    task automatic test_lw();
        int got;
        preload(12'h100, 8'h11); preload(12'h101, 8'h22); preload(12'h102, 8'h33); preload(12'h103, 8'h44);
        to_mem_addr = 32'h100; requiring_length = 2'b10; lsb_load_signed = 1'b0; lsb_read_signal = 1'b1;
        got = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k <= 4) begin
                checks++;
                if (mem_a !== 32'h100 + 32'(k - 1) || mem_wr !== 1'b0) begin
                    errors++; $display("FAIL lw_addr_%0d: got %h wr=%b want %h wr=0", k, mem_a, mem_wr, 32'h100 + 32'(k - 1)); end
            end
            if (mem_load_success) begin got = k; break; end
        end
        checks++; if (got != 6) begin errors++; $display("FAIL lw_latency: got cycle %0d want 6", got); end
        checks++; if (from_mem_data !== 32'h44332211) begin errors++; $display("FAIL lw_data: got %h want 44332211", from_mem_data); end
        lsb_read_signal = 1'b0;
        tick();
        checks++; if (mem_load_success !== 1'b0) begin errors++; $display("FAIL lw_pulse_width: got %b want 0", mem_load_success); end
    endtask

    task automatic test_lb();
        int got;
        preload(12'h180, 8'h80); preload(12'h190, 8'h34); preload(12'h191, 8'h92);
        do_load(32'h180, 2'b00, 1'b1, got);
        checks++; if (got != 3) begin errors++; $display("FAIL lb_latency: got cycle %0d want 3", got); end
        checks++; if (from_mem_data !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_data: got %h want ffffff80", from_mem_data); end
        do_load(32'h180, 2'b00, 1'b0, got);
        checks++; if (got != 3 || from_mem_data !== 32'h00000080) begin
            errors++; $display("FAIL lbu: got cycle %0d data %h want 3 00000080", got, from_mem_data); end
        do_load(32'h190, 2'b01, 1'b1, got);
        checks++; if (got != 4 || from_mem_data !== 32'hFFFF9234) begin
            errors++; $display("FAIL lh: got cycle %0d data %h want 4 ffff9234", got, from_mem_data); end
    endtask

    task automatic test_sh();
        logic [31:0] ea [0:1];
        logic [7:0]  ed [0:1];
        ea[0] = 32'h200; ea[1] = 32'h201; ed[0] = 8'hEF; ed[1] = 8'hBE;
        to_mem_addr = 32'h200; to_mem_data = 32'h0000BEEF; requiring_length = 2'b01; lsb_write_signal = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            tick();
            checks++;
            if (mem_wr !== 1'b1 || mem_a !== ea[k-1] || mem_dout !== ed[k-1] || mem_store_success !== 1'b0) begin
                errors++; $display("FAIL sh_byte_%0d: got wr=%b a=%h d=%h ss=%b want 1 %h %h 0",
                                   k - 1, mem_wr, mem_a, mem_dout, mem_store_success, ea[k-1], ed[k-1]); end
        end
        tick();
        checks++; if (mem_store_success !== 1'b1 || mem_wr !== 1'b0) begin
            errors++; $display("FAIL sh_success: got ss=%b wr=%b want 1 0", mem_store_success, mem_wr); end
        lsb_write_signal = 1'b0;
        tick();
        checks++; if (mem_store_success !== 1'b0 || mem_wr !== 1'b0) begin
            errors++; $display("FAIL sh_after: got ss=%b wr=%b want 0 0", mem_store_success, mem_wr); end
        checks++; if (ram[12'h200] !== 8'hEF || ram[12'h201] !== 8'hBE) begin
            errors++; $display("FAIL sh_ram: got %h %h want ef be", ram[12'h200], ram[12'h201]); end
    endtask

    task automatic test_back_to_back();
        int first, n;
        preload(12'h300, 8'h13); preload(12'h301, 8'h05); preload(12'h302, 8'h00); preload(12'h303, 8'h00);
        if_addr = 32'h300; if_read_signal = 1'b1;
        to_mem_addr = 32'h210; to_mem_data = 32'h0000005A; requiring_length = 2'b00; lsb_write_signal = 1'b1;
        tick();
        checks++; if (mem_wr !== 1'b1 || mem_a !== 32'h210) begin
            errors++; $display("FAIL b2b_write_first: got wr=%b a=%h want 1 00000210", mem_wr, mem_a); end
        tick();
        checks++; if (mem_store_success !== 1'b1 || if_success !== 1'b0) begin
            errors++; $display("FAIL b2b_store: got ss=%b if=%b want 1 0", mem_store_success, if_success); end
        lsb_write_signal = 1'b0;
        first = 0; n = 0;
        for (int k = 3; k <= 14; k++) begin
            tick();
            if (if_success) begin n++; if (first == 0) first = k; if_read_signal = 1'b0; end
        end
        if_read_signal = 1'b0;
        checks++; if (n != 1 || first != 9) begin
            errors++; $display("FAIL b2b_if: got %0d pulses first at %0d want 1 at 9", n, first); end
        checks++; if (if_data !== 32'h00000513) begin errors++; $display("FAIL b2b_if_data: got %h want 00000513", if_data); end
    endtask

    task automatic test_flush_if();
        int n;
        if_addr = 32'h300; if_read_signal = 1'b1;
        tick();
        tick();
        jump_wrong = 1'b1; if_read_signal = 1'b0;
        tick();
        jump_wrong = 1'b0;
        checks++; if (mem_a !== 32'h0) begin errors++; $display("FAIL flush_if_idle: got mem_a %h want 0", mem_a); end
        n = 0;
        for (int k = 0; k < 8; k++) begin
            if (if_success) n++;
            tick();
        end
        checks++; if (n != 0) begin errors++; $display("FAIL flush_if_pulse: got %0d pulses want 0", n); end
        checks++; if (if_data !== 32'h00000513) begin errors++; $display("FAIL flush_if_data: got %h want 00000513", if_data); end
    endtask

    task automatic test_flush_sw();
        int nw, got;
        to_mem_addr = 32'h400; to_mem_data = 32'hCAFEF00D; requiring_length = 2'b10; lsb_write_signal = 1'b1;
        nw = 0; got = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            jump_wrong = (k <= 3);
            if (mem_wr) nw++;
            if (mem_store_success) begin got = k; break; end
        end
        lsb_write_signal = 1'b0; jump_wrong = 1'b0;
        checks++; if (nw != 4 || got != 5) begin
            errors++; $display("FAIL flush_sw: got %0d bytes pulse at %0d want 4 at 5", nw, got); end
        tick();
        checks++; if ({ram[12'h403], ram[12'h402], ram[12'h401], ram[12'h400]} !== 32'hCAFEF00D) begin
            errors++; $display("FAIL flush_sw_ram: got %h%h%h%h want cafef00d", ram[12'h403], ram[12'h402], ram[12'h401], ram[12'h400]); end
        jump_wrong = 1'b1; to_mem_addr = 32'h100; requiring_length = 2'b10; lsb_read_signal = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (mem_a !== 32'h0 || mem_load_success !== 1'b0) begin
                errors++; $display("FAIL flush_read_block_%0d: got a=%h ls=%b want 0 0", k, mem_a, mem_load_success); end
        end
        lsb_read_signal = 1'b0; jump_wrong = 1'b0;
        tick();
    endtask

    task automatic test_rdy_hold();
        int got;
        to_mem_addr = 32'h180; requiring_length = 2'b00; lsb_load_signed = 1'b0; lsb_read_signal = 1'b1;
        got = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            rdy = !(k == 1 || k == 2);
            if (mem_load_success) begin got = k; break; end
        end
        rdy = 1'b1; lsb_read_signal = 1'b0;
        tick();
        checks++; if (got != 5 || from_mem_data !== 32'h00000080) begin
            errors++; $display("FAIL rdy_hold: got cycle %0d data %h want 5 00000080", got, from_mem_data); end
    endtask

    task automatic test_io();
        int got;
        to_mem_addr = 32'h30000; to_mem_data = 32'h00000077; requiring_length = 2'b00; lsb_write_signal = 1'b1;
        io_buffer_full = 1'b1;
`ifdef MEMCTRL_IO_STALL_EN
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL io_stall_%0d: got wr=%b want 0", k, mem_wr); end
        end
        io_buffer_full = 1'b0;
        #1;
        checks++; if (mem_wr !== 1'b1 || mem_a !== 32'h30000) begin
            errors++; $display("FAIL io_release: got wr=%b a=%h want 1 00030000", mem_wr, mem_a); end
        got = 0;
        for (int k = 4; k <= 10; k++) begin
            tick();
            if (mem_store_success) begin got = k; break; end
        end
        checks++; if (got != 4) begin errors++; $display("FAIL io_success: got cycle %0d want 4", got); end
`else
        tick();
        checks++; if (mem_wr !== 1'b1 || mem_a !== 32'h30000 || mem_dout !== 8'h77) begin
            errors++; $display("FAIL io_ignored: got wr=%b a=%h d=%h want 1 00030000 77", mem_wr, mem_a, mem_dout); end
        got = 0;
        for (int k = 2; k <= 10; k++) begin
            tick();
            if (mem_store_success) begin got = k; break; end
        end
        checks++; if (got != 2) begin errors++; $display("FAIL io_success: got cycle %0d want 2", got); end
`endif
        lsb_write_signal = 1'b0; io_buffer_full = 1'b0;
        tick();
    endtask

    task automatic test_wrap();
        int got;
        logic [31:0] ea;
        preload(12'hFFE, 8'hA1); preload(12'hFFF, 8'hB2); preload(12'h000, 8'hC3); preload(12'h001, 8'hD4);
        to_mem_addr = 32'hFFFFFFFE; requiring_length = 2'b10; lsb_load_signed = 1'b1; lsb_read_signal = 1'b1;
        got = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k <= 4) begin
                ea = 32'hFFFFFFFE + 32'(k - 1);
                checks++; if (mem_a !== ea) begin errors++; $display("FAIL wrap_addr_%0d: got %h want %h", k, mem_a, ea); end
            end
            if (mem_load_success) begin got = k; break; end
        end
        lsb_read_signal = 1'b0;
        tick();
        checks++; if (got != 6 || from_mem_data !== 32'hD4C3B2A1) begin
            errors++; $display("FAIL wrap_data: got cycle %0d data %h want 6 d4c3b2a1", got, from_mem_data); end
    endtask

    task automatic test_reset_mid();
        int n;
        to_mem_addr = 32'h500; to_mem_data = 32'h01020304; requiring_length = 2'b10; lsb_write_signal = 1'b1;
        tick();
        tick();
        rst = 1'b1; lsb_write_signal = 1'b0;
        tick();
        rst = 1'b0;
        checks++; if (mem_wr !== 1'b0 || mem_a !== 32'h0 || from_mem_data !== 32'h0) begin
            errors++; $display("FAIL reset_mid: got wr=%b a=%h d=%h want 0 0 0", mem_wr, mem_a, from_mem_data); end
        n = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (mem_store_success || mem_wr) n++;
        end
        checks++; if (n != 0) begin errors++; $display("FAIL reset_mid_quiet: got %0d active cycles want 0", n); end
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; jump_wrong = 1'b0;
        lsb_read_signal = 1'b0; lsb_write_signal = 1'b0; lsb_load_signed = 1'b0;
        requiring_length = 2'b00; to_mem_addr = 32'h0; to_mem_data = 32'h0;
        if_read_signal = 1'b0; if_addr = 32'h0; io_buffer_full = 1'b0;
        test_reset();
        test_lw();
        test_lb();
        test_sh();
        test_back_to_back();
        test_flush_if();
        test_flush_sw();
        test_rdy_hold();
        test_io();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory controller that arbitrates the load/store buffer and instruction fetch onto the single byte-wide RAM/IO bus. It serialises 8/16/32-bit requests into byte accesses, assembles little-endian load data, and returns one-cycle success pulses to the requester. It is the responder side of the LSB memory handshake: `lsb_read_signal`/`lsb_write_signal` in, `mem_load_success`/`mem_store_success` out.

## Interface
- `ADDR_W`, default 32: address width.
- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `rdy` in 1: when low, every register holds its value.
- `jump_wrong` in 1: misprediction flush.
- `lsb_read_signal` in 1: LSB load request, held until `mem_load_success`.
- `lsb_write_signal` in 1: LSB store request, held until `mem_store_success`.
- `requiring_length` in 2: 2'b00 byte, 2'b01 half, 2'b10 word.
- `lsb_load_signed` in 1: sign-extend load result.
- `to_mem_addr` in ADDR_W: LSB address.
- `to_mem_data` in 32: store data.
- `mem_load_success` out 1: one-cycle pulse; `from_mem_data` is valid in the same cycle.
- `mem_store_success` out 1: one-cycle pulse.
- `from_mem_data` out 32: extended load result.
- `if_read_signal` in 1: fetch request, word only.
- `if_addr` in ADDR_W: fetch address.
- `if_success` out 1: one-cycle pulse.
- `if_data` out 32: fetched instruction.
- `mem_din` in 8: RAM read data.
- `mem_dout` out 8: RAM write data.
- `mem_a` out ADDR_W: RAM address.
- `mem_wr` out 1: 1 = write.
- `io_buffer_full` in 1: UART buffer full.

## Operation
- Reset values: all outputs 0, state IDLE, byte counter 0.
- States:
  - IDLE: accept a request.
  - BUSY: stream bytes.
  - DONE: one-cycle guard. The success pulse is high here, and no request is accepted because the requester is still de-asserting.
- Transitions:
  - IDLE→BUSY on accept.
  - BUSY→DONE after the last byte.
  - BUSY→IDLE on flush abort.
  - DONE→IDLE unconditionally.
- Priority in IDLE: LSB write, then LSB read, then IF. Selection is latched at accept; requester inputs are ignored while BUSY/DONE.
- Byte count N = 1/2/4 from `requiring_length`; IF always uses N = 4.
- Byte i uses address base+i. Load data byte i fills bits [8i+7:8i]. Store drives `to_mem_data[8i+7:8i]`.
- Load extension:
  - N = 1: bit 7 if signed, else zero.
  - N = 2: bit 15 if signed, else zero.
  - N = 4: no extension.
- Flush (`jump_wrong` = 1):
  - Any in-flight LSB read or IF goes to IDLE next edge with no success pulse.
  - An accepted write always completes.
  - In IDLE, reads and IF are not accepted while `jump_wrong` = 1; writes are.
- Arithmetic: base+i wraps modulo 2^ADDR_W.

## Timing
- Accept at edge E0.
- Write:
  - Byte i is presented (`mem_a`, `mem_dout`, `mem_wr` = 1) after edge E0+i.
  - After edge E0+N, `mem_wr` = 0 and success is high, for one cycle.
  - Word store pulses after E0+4; byte store after E0+1.
- Read:
  - Address i is presented after edge E0+i, with `mem_wr` = 0.
  - `mem_din` for byte i is sampled at edge E0+i+2.
  - Success and data are registered at edge E0+N+1: word after E0+5, byte after E0+2.
- DONE lasts exactly one cycle. Earliest next accept is the edge ending DONE+1, i.e. a back-to-back gap of one idle cycle.
- `from_mem_data`/`if_data` hold their value until the next completion.
- Reset mid-access: the next edge returns to IDLE with `mem_wr` = 0, and no pulse is issued.

## Configuration
- `MEMCTRL_IO_STALL_EN` defined:
  - A write byte to an address with `addr[17:16]` = 2'b11 is held (counter frozen, `mem_wr` = 0) while `io_buffer_full` = 1.
  - It proceeds on the first cycle `io_buffer_full` = 0.
- Undefined: `io_buffer_full` is ignored and timing is always as above.

## Test plan
- LSB LW from 0x100, RAM bytes 11 22 33 44 → `mem_load_success` pulse after E0+5, `from_mem_data` = 0x44332211; `mem_a` steps 0x100..0x103.
- LB signed from byte 0x80 → 0xFFFFFF80; LBU → 0x00000080; success after E0+2.
- SH 0xBEEF to 0x200 → `mem_wr` high two cycles with (0x200, EF), (0x201, BE); `mem_store_success` pulse after E0+2, then DONE, then IDLE.
- Same-cycle `if_read_signal` and `lsb_write_signal` → write serviced first; IF accepted at the edge ending DONE+1; `if_success` pulses once.
- `jump_wrong` pulse two cycles into an IF word read → no `if_success`, IDLE next edge; `jump_wrong` during a SW → all 4 bytes written, store pulse issued.
- With `MEMCTRL_IO_STALL_EN` defined: SB to 0x30000 with `io_buffer_full` high 3 cycles → `mem_wr` stays 0 for 3 cycles, write occurs on the 4th, success follows.
